// File: rtl/shiftreg_responder.sv
// shiftreg_responder: emulated parallel-in/serial-out button shift register
// answering the SHIFT_CLKIN / SHIFT_LOAD / SHIFT_OUT strobes of shiftregctl.
module shiftreg_responder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          INVERT      = 1'b0
) (
  input  logic             clock_50m,
  input  logic             reset_n,
  input  logic             shiftreg_clk,
  input  logic             shiftreg_loadn,
  output logic             shiftreg_out,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             frame_done,
  output logic             overrun,
  output logic [15:0]      load_count
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  typedef enum logic {
    MODE_LOAD  = 1'b0,
    MODE_SHIFT = 1'b1
  } mode_e;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] loadn_sync;
  logic                   clk_s;
  logic                   loadn_s;
  logic                   clk_prev;
  logic                   loadn_prev;
  logic                   clk_rise;
  mode_e                  mode;

  logic [WIDTH-1:0]       sr;
  logic [CW-1:0]          cnt;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign loadn_s  = loadn_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;

  // Mode is the synchronized load strobe level; no stored state is needed.
  always_comb begin
    mode = loadn_s ? MODE_SHIFT : MODE_LOAD;
  end

  // Synchronizers and edge-history flops idle high so reset exit is edge-free.
  always_ff @(posedge clock_50m) begin
    if (!reset_n) begin
      clk_sync   <= '1;
      loadn_sync <= '1;
      clk_prev   <= 1'b1;
      loadn_prev <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], shiftreg_clk};
      loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], shiftreg_loadn};
      clk_prev   <= clk_s;
      loadn_prev <= loadn_s;
    end
  end

  // Shift register, bit counter and status outputs; load has priority over shift.
  always_ff @(posedge clock_50m) begin
    if (!reset_n) begin
      sr           <= '0;
      cnt          <= '0;
      shiftreg_out <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      load_count   <= '0;
    end else begin
      frame_done   <= 1'b0;
      shiftreg_out <= sr[WIDTH-1];
      if (mode == MODE_LOAD) begin
        sr      <= parallel_in ^ {WIDTH{INVERT}};
        cnt     <= '0;
        overrun <= 1'b0;
        if (loadn_prev) begin
          load_count <= load_count + 16'd1;
        end
      end else if (clk_rise) begin
        sr <= {sr[WIDTH-2:0], ser_in};
        if (cnt != CNT_SAT) begin
          cnt <= cnt + CW'(1);
        end
        if (cnt == CNT_LAST) begin
          frame_done <= 1'b1;
        end
        if (cnt >= CNT_FULL) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_responder.sv
// Bench for shiftreg_responder: two instances (INVERT=0 and INVERT=1) share
// the strobes; a queue model of the serial stream predicts every output.
module tb_shiftreg_responder;

  logic        clock_50m = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        loadn = 1'b1;
  logic        ser_in = 1'b0;
  logic [15:0] parallel_in = '0;

  logic        out0, out1, fd0, fd1, ov0, ov1;
  logic [15:0] lc0, lc1;

  shiftreg_responder #(.WIDTH(16), .SYNC_STAGES(2), .INVERT(1'b0)) u_dut (
    .clock_50m(clock_50m), .reset_n(reset_n), .shiftreg_clk(sclk),
    .shiftreg_loadn(loadn), .shiftreg_out(out0), .ser_in(ser_in),
    .parallel_in(parallel_in), .frame_done(fd0), .overrun(ov0), .load_count(lc0)
  );

  shiftreg_responder #(.WIDTH(16), .SYNC_STAGES(2), .INVERT(1'b1)) u_inv (
    .clock_50m(clock_50m), .reset_n(reset_n), .shiftreg_clk(sclk),
    .shiftreg_loadn(loadn), .shiftreg_out(out1), .ser_in(ser_in),
    .parallel_in(parallel_in), .frame_done(fd1), .overrun(ov1), .load_count(lc1)
  );

  always #5 clock_50m = ~clock_50m;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the controller should see, bit by bit, MSB first.
  bit          q0[$];
  bit          q1[$];
  int          shifts = 0;
  int          frames_exp = 0;
  logic [15:0] loads_m = '0;
  int          frames0 = 0;
  int          frames1 = 0;

  always @(negedge clock_50m) begin
    if (fd0 === 1'b1) frames0++;
    if (fd1 === 1'b1) frames1++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock_50m);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_capture(input logic [15:0] w);
    q0.delete();
    q1.delete();
    for (int i = 15; i >= 0; i--) begin
      q0.push_back(w[i]);
      q1.push_back(~w[i]);
    end
    shifts = 0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clock_50m);
    check($sformatf("%s_out0", tag), 32'(out0), 32'(q0[0]));
    check($sformatf("%s_out1", tag), 32'(out1), 32'(q1[0]));
    check($sformatf("%s_ovr0", tag), 32'(ov0), 32'(shifts > 16));
    check($sformatf("%s_ovr1", tag), 32'(ov1), 32'(shifts > 16));
    check($sformatf("%s_lcnt0", tag), 32'(lc0), 32'(loads_m));
    check($sformatf("%s_lcnt1", tag), 32'(lc1), 32'(loads_m));
    check($sformatf("%s_frm0", tag), 32'(frames0), 32'(frames_exp));
    check($sformatf("%s_frm1", tag), 32'(frames1), 32'(frames_exp));
  endtask

  task automatic load_word(input string tag, input logic [15:0] w);
    parallel_in = w;
    loadn = 1'b0;
    cyc(4);
    loadn = 1'b1;
    cyc(3);
    model_capture(w);
    loads_m = loads_m + 16'd1;
    check_all(tag);
  endtask

  task automatic do_shift(input string tag, input logic sin);
    ser_in = sin;
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
    cyc(4);
    shifts++;
    if (shifts == 16) frames_exp++;
    void'(q0.pop_front());
    void'(q1.pop_front());
    q0.push_back(sin);
    q1.push_back(sin);
    check_all(tag);
  endtask

  initial begin
    logic [15:0] w;
    int n;

    // Reset, then idle strobes.
    model_capture(16'h0000);
    for (int i = 0; i < 16; i++) q1[i] = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(20);
    check_all("idle");

    // Known word, one full frame.
    load_word("a5c3_load", 16'hA5C3);
    for (int i = 1; i <= 16; i++) do_shift($sformatf("a5c3_s%0d", i), 1'($urandom_range(0, 1)));

    // Cascade input and overrun beyond the frame.
    load_word("ser_load", 16'h0001);
    for (int i = 1; i <= 18; i++) do_shift($sformatf("ser_s%0d", i), 1'b1);

    // Next load clears overrun; random frames of varying length.
    for (int f = 0; f < 3; f++) begin
      w = 16'($urandom);
      load_word($sformatf("rnd%0d_load", f), w);
      n = $urandom_range(14, 20);
      for (int i = 1; i <= n; i++) do_shift($sformatf("rnd%0d_s%0d", f, i), 1'($urandom_range(0, 1)));
    end

    // Clock edge while load is held: no shift, output follows parallel_in.
    parallel_in = 16'h8000;
    loadn = 1'b0;
    cyc(4);
    sclk = 1'b1;
    cyc(4);
    model_capture(16'h8000);
    loads_m = loads_m + 16'd1;
    check_all("ldclk_8000");
    parallel_in = 16'h0000;
    cyc(4);
    sclk = 1'b0;
    cyc(4);
    model_capture(16'h0000);
    check_all("ldclk_0000");
    loadn = 1'b1;
    cyc(3);
    for (int i = 1; i <= 16; i++) do_shift($sformatf("ldclk_s%0d", i), 1'($urandom_range(0, 1)));

    // Reset mid-frame discards the frame.
    w = 16'($urandom);
    load_word("mid_load", w);
    for (int i = 1; i <= 7; i++) do_shift($sformatf("mid_s%0d", i), 1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    cyc(1);
    @(negedge clock_50m);
    check("rst_out0", 32'(out0), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    check("rst_fd0", 32'(fd0), 32'd0);
    check("rst_fd1", 32'(fd1), 32'd0);
    check("rst_ovr0", 32'(ov0), 32'd0);
    check("rst_ovr1", 32'(ov1), 32'd0);
    check("rst_lcnt0", 32'(lc0), 32'd0);
    check("rst_lcnt1", 32'(lc1), 32'd0);
    reset_n = 1'b1;
    model_capture(16'h0000);
    for (int i = 0; i < 16; i++) q1[i] = 1'b0;
    loads_m = '0;
    cyc(3);
    for (int i = 1; i <= 17; i++) do_shift($sformatf("post_s%0d", i), 1'($urandom_range(0, 1)));

    // 65537 load pulses wrap the counter around to 1.
    w = 16'($urandom);
    parallel_in = w;
    repeat (65537) begin
      loadn = 1'b0;
      cyc(1);
      loadn = 1'b1;
      cyc(1);
    end
    cyc(3);
    model_capture(w);
    loads_m = loads_m + 16'(65537);
    check_all("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
